axi_cmd_sequencer: RTL and testbench

- Parametrised successor to the switch-driven user-side AXI-Lite command generator.
- On a start pulse it issues a burst of NUM_REGS single-beat write commands, or skips them, then issues read commands to the same register window with a true VALID/READY handshake.
- It compares read data against expected values and reports the result on LEDs and status flags.
- Sits between board I/O (switches, LEDs) and the AXI-Lite master's user command interface.

---
 rtl/axi_cmd_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_axi_cmd_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_cmd_sequencer.sv
// AXI-Lite user-side command sequencer: optional write burst over a register window,
// then a read-back pass with data comparison, reporting through LEDs and status flags.
module axi_cmd_sequencer #(
    parameter int unsigned        ADDR_W     = 32,
    parameter int unsigned        DATA_W     = 32,
    parameter int unsigned        NUM_REGS   = 4,
    parameter logic [ADDR_W-1:0]  BASE_ADDR  = '0,
    parameter int unsigned        GAP_CYCLES = 4,
    parameter int unsigned        TIMEOUT    = 1024,
    parameter int unsigned        LED_W      = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [15:0]           SW,
    input  logic                  start,
    output logic                  C_VALID,
    input  logic                  C_READY,
    output logic [ADDR_W-1:0]     C_ADRR,
    output logic [DATA_W-1:0]     C_DATA,
    output logic [DATA_W/8-1:0]   C_STRB,
    output logic                  C_VALID_R,
    input  logic                  C_READY_R,
    output logic [ADDR_W-1:0]     C_ADRR_R,
    input  logic                  R_VALID,
    input  logic [DATA_W-1:0]     R_DATA,
    output logic [LED_W-1:0]      led,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [7:0]            err_cnt
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_REQ  = 3'd1;
    localparam logic [2:0] WR_GAP  = 3'd2;
    localparam logic [2:0] RD_REQ  = 3'd3;
    localparam logic [2:0] RD_WAIT = 3'd4;
    localparam logic [2:0] RD_GAP  = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;

    logic [2:0]        state_q, state_d;
    logic              mode_q, mode_d;
    logic [14:0]       seed_q, seed_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        gap_q, gap_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [LED_W-1:0]  led_q, led_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic              last_idx;
    logic              gap_done;
    logic              timeout_hit;
    logic              rd_fail;
    logic [DATA_W-1:0] expected;
    logic [ADDR_W-1:0] reg_addr;

    assign last_idx    = (idx_q == IDX_W'(NUM_REGS - 1));
    // A zero gap still spends the single gap-state cycle before the next request.
    assign gap_done    = (GAP_CYCLES == 0) || (gap_q == 8'(GAP_CYCLES - 1));
    assign timeout_hit = (to_q == TO_W'(TIMEOUT - 1));
    assign expected    = DATA_W'(seed_q) + DATA_W'(idx_q);
    assign reg_addr    = BASE_ADDR + ADDR_W'(idx_q) * ADDR_W'(STRB_W);

    // Command outputs are decoded from state; payloads are zero whenever VALID is low.
    always_comb begin
        C_VALID   = (state_q == WR_REQ);
        C_ADRR    = C_VALID ? reg_addr : '0;
        C_DATA    = C_VALID ? expected : '0;
        C_STRB    = C_VALID ? {STRB_W{1'b1}} : '0;
        C_VALID_R = (state_q == RD_REQ);
        C_ADRR_R  = C_VALID_R ? reg_addr : '0;
        led       = led_q;
        busy      = busy_q;
        done      = done_q;
        err       = err_q;
        err_cnt   = err_cnt_q;
    end

    // Next-state logic for the sequencer FSM, counters and status flags.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        seed_d    = seed_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        to_d      = to_q;
        led_d     = led_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        rd_fail   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mode_d    = SW[15];
                    seed_d    = SW[14:0];
                    idx_d     = '0;
                    gap_d     = '0;
                    to_d      = '0;
                    err_d     = 1'b0;
                    err_cnt_d = '0;
                    done_d    = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = SW[15] ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                if (C_READY) begin
                    gap_d   = '0;
                    state_d = WR_GAP;
                end
            end
            WR_GAP, RD_GAP: begin
                if (gap_done) begin
                    gap_d = '0;
                    if (last_idx) begin
                        idx_d = '0;
                        if (state_q == WR_GAP) begin
                            state_d = RD_REQ;
                        end else begin
                            state_d = DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = (state_q == WR_GAP) ? WR_REQ : RD_REQ;
                    end
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            RD_REQ: begin
                if (C_READY_R) begin
                    to_d    = '0;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (R_VALID) begin
                    led_d   = R_DATA[LED_W-1:0];
                    rd_fail = mode_q && (R_DATA != expected);
                    state_d = RD_GAP;
                end else if (timeout_hit) begin
                    rd_fail = 1'b1;
                    state_d = RD_GAP;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (rd_fail) begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    // State registers; reset abandons any in-flight command.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            seed_q    <= '0;
            idx_q     <= '0;
            gap_q     <= '0;
            to_q      <= '0;
            led_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            seed_q    <= seed_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            to_q      <= to_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_axi_cmd_sequencer.sv
// Directed bench for axi_cmd_sequencer with a small echoing memory responder.
module tb_axi_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] SW;
    logic        start;
    logic        C_VALID;
    logic        C_READY;
    logic [31:0] C_ADRR;
    logic [31:0] C_DATA;
    logic [3:0]  C_STRB;
    logic        C_VALID_R;
    logic        C_READY_R;
    logic [31:0] C_ADRR_R;
    logic        R_VALID;
    logic [31:0] R_DATA;
    logic [14:0] led;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  err_cnt;

    int checks   = 0;
    int failures = 0;

    // Responder state and logs
    logic [31:0] mem [4];
    logic [31:0] wr_addr_log [8];
    logic [31:0] wr_data_log [8];
    logic [3:0]  wr_strb_log [8];
    logic [31:0] rd_addr_log [8];
    int          wr_cnt, rd_cnt, valid_cycles, both_cnt;
    int          hold_cnt;
    logic [31:0] hold_addr, hold_data;
    logic        corrupt8, drop4;
    int          rd_wait;
    logic [31:0] rd_data;

    axi_cmd_sequencer #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .NUM_REGS  (4),
        .BASE_ADDR (32'h0),
        .GAP_CYCLES(4),
        .TIMEOUT   (16),
        .LED_W     (15)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .SW       (SW),
        .start    (start),
        .C_VALID  (C_VALID),
        .C_READY  (C_READY),
        .C_ADRR   (C_ADRR),
        .C_DATA   (C_DATA),
        .C_STRB   (C_STRB),
        .C_VALID_R(C_VALID_R),
        .C_READY_R(C_READY_R),
        .C_ADRR_R (C_ADRR_R),
        .R_VALID  (R_VALID),
        .R_DATA   (R_DATA),
        .led      (led),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Responder: decides at each falling edge what the next rising edge will see.
    initial begin
        C_READY   = 1'b1;
        C_READY_R = 1'b1;
        R_VALID   = 1'b0;
        R_DATA    = '0;
        rd_wait   = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                R_VALID = 1'b0;
                rd_wait = 0;
                C_READY = 1'b1;
            end else begin
                R_VALID = 1'b0;
                if (rd_wait > 0) begin
                    rd_wait--;
                    if (rd_wait == 0) begin
                        R_VALID = 1'b1;
                        R_DATA  = rd_data;
                    end
                end
                if (C_VALID && C_VALID_R) both_cnt++;
                if (C_VALID) begin
                    valid_cycles++;
                    if (hold_cnt > 0) begin
                        C_READY = 1'b0;
                        hold_cnt--;
                        check_eq("hold_addr", C_ADRR, hold_addr);
                        check_eq("hold_data", C_DATA, hold_data);
                    end else begin
                        C_READY = 1'b1;
                        if (wr_cnt < 8) begin
                            wr_addr_log[wr_cnt] = C_ADRR;
                            wr_data_log[wr_cnt] = C_DATA;
                            wr_strb_log[wr_cnt] = C_STRB;
                        end
                        mem[C_ADRR[3:2]] = C_DATA;
                        wr_cnt++;
                    end
                end else begin
                    C_READY = 1'b1;
                end
                if (C_VALID_R && C_READY_R) begin
                    if (rd_cnt < 8) rd_addr_log[rd_cnt] = C_ADRR_R;
                    rd_cnt++;
                    rd_data = mem[C_ADRR_R[3:2]];
                    if (corrupt8 && C_ADRR_R == 32'h8) rd_data = 32'h0;
                    if (!(drop4 && C_ADRR_R == 32'h4)) rd_wait = 2;
                end
            end
        end
    end

    task automatic clear_logs();
        wr_cnt       = 0;
        rd_cnt       = 0;
        valid_cycles = 0;
    endtask

    task automatic run_start(input logic [15:0] sw);
        @(negedge clk);
        SW    = sw;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, done, 1);
    endtask

    task automatic check_writes(input string tag, input logic [31:0] seed);
        check_eq({tag, "_wr_cnt"}, wr_cnt, 4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("%s_wr_addr%0d", tag, i), wr_addr_log[i], 32'(i * 4));
            check_eq($sformatf("%s_wr_data%0d", tag, i), wr_data_log[i], seed + 32'(i));
            check_eq($sformatf("%s_wr_strb%0d", tag, i), wr_strb_log[i], 4'hF);
        end
    endtask

    task automatic check_reads(input string tag);
        check_eq({tag, "_rd_cnt"}, rd_cnt, 4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("%s_rd_addr%0d", tag, i), rd_addr_log[i], 32'(i * 4));
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        SW        = '0;
        start     = 1'b0;
        corrupt8  = 1'b0;
        drop4     = 1'b0;
        hold_cnt  = 0;
        hold_addr = '0;
        hold_data = '0;
        both_cnt  = 0;
        for (int i = 0; i < 4; i++) mem[i] = '0;
        clear_logs();
        repeat (3) @(negedge clk);
        check_eq("rst_c_valid", C_VALID, 0);
        check_eq("rst_c_valid_r", C_VALID_R, 0);
        check_eq("rst_c_strb", C_STRB, 0);
        check_eq("rst_led", led, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_err_cnt", err_cnt, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: write + readback, echoing memory; a start while busy must be ignored
        clear_logs();
        run_start(16'h8005);
        check_eq("t1_first_valid", C_VALID, 1);
        check_eq("t1_busy", busy, 1);
        repeat (3) @(negedge clk);
        SW    = 16'h0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t1_done");
        check_writes("t1", 32'h5);
        check_reads("t1");
        check_eq("t1_err", err, 0);
        check_eq("t1_err_cnt", err_cnt, 0);
        check_eq("t1_led", led, 15'h0008);
        check_eq("t1_busy_end", busy, 0);

        // 2: read of address 0x8 corrupted
        clear_logs();
        corrupt8 = 1'b1;
        run_start(16'h8005);
        wait_done("t2_done");
        corrupt8 = 1'b0;
        check_eq("t2_err", err, 1);
        check_eq("t2_err_cnt", err_cnt, 1);
        check_eq("t2_led", led, 15'h0008);

        // 3: read-only against preloaded memory
        clear_logs();
        mem[0] = 32'h11;
        mem[1] = 32'h22;
        mem[2] = 32'h33;
        mem[3] = 32'h44;
        run_start(16'h0000);
        wait_done("t3_done");
        check_eq("t3_valid_cycles", valid_cycles, 0);
        check_reads("t3");
        check_eq("t3_led", led, 15'h0044);
        check_eq("t3_err", err, 0);

        // 4: first write held off for 10 cycles
        clear_logs();
        hold_cnt  = 10;
        hold_addr = 32'h0;
        hold_data = 32'h5;
        run_start(16'h8005);
        wait_done("t4_done");
        check_eq("t4_hold_used", hold_cnt, 0);
        check_writes("t4", 32'h5);
        check_eq("t4_err", err, 0);

        // 5: no response for address 0x4, run continues after timeout
        clear_logs();
        drop4 = 1'b1;
        run_start(16'h8005);
        wait_done("t5_done");
        drop4 = 1'b0;
        check_reads("t5");
        check_eq("t5_err", err, 1);
        check_eq("t5_err_cnt", err_cnt, 1);
        check_eq("t5_led", led, 15'h0008);

        // 6: reset during RD_WAIT, then a clean rerun
        clear_logs();
        run_start(16'h8005);
        begin
            int n = 0;
            while (rd_cnt == 0 && n < 500) begin
                @(negedge clk);
                #1;
                n++;
            end
            check_eq("t6_reached_read", rd_cnt != 0, 1);
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_eq("t6_rst_c_valid_r", C_VALID_R, 0);
            check_eq("t6_rst_led", led, 0);
            check_eq("t6_rst_busy", busy, 0);
            check_eq("t6_rst_done", done, 0);
            check_eq("t6_rst_err_cnt", err_cnt, 0);
            @(negedge clk);
            #1;
        end
        check_eq("t6_rst_c_valid", C_VALID, 0);
        check_eq("t6_rst_c_strb", C_STRB, 0);
        check_eq("t6_rst_c_adrr_r", C_ADRR_R, 0);
        check_eq("t6_rst_err", err, 0);
        @(negedge clk);
        reset_n = 1'b1;
        clear_logs();
        run_start(16'h8005);
        wait_done("t6_done");
        check_writes("t6", 32'h5);
        check_eq("t6_err", err, 0);
        check_eq("t6_err_cnt", err_cnt, 0);
        check_eq("t6_led", led, 15'h0008);

        check_eq("never_both_valid", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
